i2c_txn_sched: RTL
==================

Name: i2c_txn_sched

Overview:
Shares one byte-level I2C master (start/stop/read/write/ack command interface with cmd_ack handshake) between NREQ register-access requesters, e.g. the startup MAC/IP EEPROM loader and runtime sensor/config clients.
- Arbitrates round-robin.
- Sequences each granted request into a full I2C register transaction.
- Returns read data, completion and error status to the winning requester.

Parameters:
NREQ, 2, number of requesters (1..8)
MAX_LEN, 4, max data bytes per transaction (1..4)
TIMEOUT, 65535, clk cycles allowed per byte-controller command before abort

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
req  in  NREQ  per-requester request level; held until own done/err
req_rw  in  NREQ  1=read, 0=write
req_sadr  in  7*NREQ  slave address per requester
req_radr  in  8*NREQ  register/word address per requester
req_len  in  3*NREQ  data byte count per requester
req_wdata  in  32*NREQ  write data, right-justified, MSB byte sent first
gnt  out  NREQ  one-hot grant, held for whole transaction
done  out  NREQ  one-cycle success pulse
err  out  NREQ  one-cycle failure pulse
rdata  out  32  read data, valid with done, zero-extended
busy  out  1  transaction in progress
bc_start, bc_stop, bc_read, bc_write  out  1 each  byte-controller commands
bc_ack_in  out  1  ack to send after a read (1=NACK)
bc_din  out  8  byte to write
bc_cmd_ack  in  1  command complete pulse
bc_ack_out  in  1  slave ack after write (1=NACK)
bc_dout  in  8  byte read
bc_al  in  1  arbitration lost

Behaviour:
- Reset: all outputs 0, FSM IDLE, round-robin pointer = requester 0.
- Command handshake:
  - Command bits and bc_din are held stable until the cycle bc_cmd_ack=1.
  - They are deasserted the following cycle.
  - Only one command is outstanding at a time.
- States and transitions:
  - IDLE: any req -> ARB.
  - ARB (1 cycle):
    - Pick first requester at or after the pointer whose req=1; assert gnt next cycle.
    - Pointer becomes winner+1 mod NREQ.
    - Latch rw/sadr/radr/len/wdata.
  - CHK: if len=0 or len>MAX_LEN -> err pulse, gnt drop, no bus activity -> IDLE.
  - SADR_W: start+write, din={sadr,0}.
  - RADR: write, din=radr.
  - Write path: WDATA sends len bytes, byte i = wdata[8*(len-1-i)+:8]; the last byte carries bc_stop.
  - Read path:
    - RSTART: start+write, din={sadr,1} (repeated start).
    - RDATA: len reads with ack_in=0, except the last, which uses ack_in=1 plus stop.
    - rdata is built as rdata={rdata[23:0],dout}, cleared at ARB.
  - DONE: done[winner] pulse, gnt cleared in the same cycle -> IDLE.
- Latency: gnt and the first bc_start rise together, 2 cycles after req rises from IDLE.
- Errors:
  - bc_ack_out=1 on any write cmd_ack -> STOPERR (stop-only command) -> err pulse -> IDLE.
  - Command timeout: per-command counter reaches TIMEOUT -> drop command -> STOPERR.
  - If the stop also times out -> err -> IDLE anyway.
  - bc_al=1 in any state -> err pulse immediately, no stop issued -> IDLE.
- Requester dropping req mid-transaction: ignored; the transaction completes and done/err still pulses.
- Simultaneous requests: strictly round-robin; a continuously requesting client waits at most NREQ-1 transactions.
- done/err are never both asserted; at most one bit of done|err is set per cycle.
- busy = (state != IDLE).
- Asynchronous reset mid-transaction: outputs clear immediately, bus left to the byte controller's own reset.

Decomposition:
- Package i2c_sched_pkg holds:
  - FSM state enumeration.
  - I2C R/W bit constants.
  - Data/length width constants.
- Sub-module rr_arbiter (NREQ-wide, request vector + pointer in, one-hot grant out).

Test Plan:
- Slave model at 7'b1010000, req0 read, radr=0xFA, len=4 -> SADR_W 0xA0, RADR 0xFA, RSTART 0xA1, 4 reads (last NACK+stop); rdata = the EEPROM bytes at 0xFA..0xFD, done[0] one pulse.
- req1 write, radr=0x10, len=2, wdata=0x0000BEEF -> bytes 0xBE, 0xEF written, stop on 0xEF; a subsequent read of len 2 returns rdata=0x0000BEEF.
- req0 and req1 both asserted in the same cycle after reset -> gnt=01 first, then gnt=10; repeat with both held -> alternation 01,10,01.
- sadr=7'h22 (no device) -> NACK on the address byte, stop issued, err pulse, rdata=0, no done.
- Hold bc_cmd_ack low (disconnected controller), TIMEOUT=100 -> err within about 200 cycles, FSM back to IDLE, busy=0.
- Edge cases:
  - len=0 -> err 1 cycle after ARB, no bc_start.
  - Assert reset_n low mid-read -> all outputs 0 asynchronously; next request starts a clean transaction.

Source files
------------

// File: rtl/i2c_txn_sched_pkg.sv
// Shared types and constants for the I2C transaction scheduler.
// The FSM state set and the byte-controller command bundle live here.
package i2c_sched_pkg;
    localparam int DATA_W    = 32;
    localparam int BYTE_W    = 8;
    localparam int LEN_W     = 3;
    localparam int SADR_BITS = 7;

    localparam logic I2C_WR = 1'b0;
    localparam logic I2C_RD = 1'b1;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ARB,
        ST_SADR_W,
        ST_RADR,
        ST_WDATA,
        ST_RSTART,
        ST_RDATA,
        ST_STOPERR,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic              start;
        logic              stop;
        logic              read;
        logic              write;
        logic              ack_in;
        logic [BYTE_W-1:0] din;
    } bc_cmd_t;
endpackage

// File: rtl/i2c_txn_sched_arb.sv
// Round-robin picker: the first requester at or after ptr wins.
// Grant is one-hot and purely combinational.
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] gnt
);
    always_comb begin
        logic found;
        gnt   = '0;
        found = 1'b0;
        // k is the distance from ptr; the smallest distance with a request wins
        for (int k = 0; k < NREQ; k++) begin
            for (int j = 0; j < NREQ; j++) begin
                if (!found && req[j] && (((j - int'(ptr) + NREQ) % NREQ) == k)) begin
                    gnt[j] = 1'b1;
                    found  = 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/i2c_txn_sched.sv
// Shares one byte-level I2C master between NREQ requesters, turning each
// granted request into a full register read or write transaction.
module i2c_txn_sched
    import i2c_sched_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int MAX_LEN = 4,
    parameter int TIMEOUT = 65535
) (
    input  logic                                clk,
    input  logic                                reset_n,
    input  logic [NREQ-1:0]                     req,
    input  logic [NREQ-1:0]                     req_rw,
    input  logic [NREQ-1:0][SADR_BITS-1:0]      req_sadr,
    input  logic [NREQ-1:0][BYTE_W-1:0]         req_radr,
    input  logic [NREQ-1:0][LEN_W-1:0]          req_len,
    input  logic [NREQ-1:0][DATA_W-1:0]         req_wdata,
    output logic [NREQ-1:0]                     gnt,
    output logic [NREQ-1:0]                     done,
    output logic [NREQ-1:0]                     err,
    output logic [DATA_W-1:0]                   rdata,
    output logic                                busy,
    output logic                                bc_start,
    output logic                                bc_stop,
    output logic                                bc_read,
    output logic                                bc_write,
    output logic                                bc_ack_in,
    output logic [BYTE_W-1:0]                   bc_din,
    input  logic                                bc_cmd_ack,
    input  logic                                bc_ack_out,
    input  logic [BYTE_W-1:0]                   bc_dout,
    input  logic                                bc_al
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    state_t                 state;
    logic [PW-1:0]          ptr, win_idx;
    logic [NREQ-1:0]        arb_gnt;
    bc_cmd_t                cmd, issue, arb_cmd;
    logic                   cmd_pend, last, len_bad, rw_q;
    logic [TW-1:0]          tmr;
    logic [LEN_W-1:0]       cnt, len_q;
    logic [1:0]             bsel;
    logic [SADR_BITS-1:0]   sadr_q;
    logic [BYTE_W-1:0]      radr_q;
    logic [DATA_W-1:0]      wdata_q;

    rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_arb (
        .req (req),
        .ptr (ptr),
        .gnt (arb_gnt)
    );

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < NREQ; i++)
            if (arb_gnt[i]) win_idx = PW'(i);
    end

    assign len_bad = (req_len[win_idx] == '0) || (req_len[win_idx] > LEN_W'(MAX_LEN));
    assign last    = (cnt == len_q - LEN_W'(1));
    // MSB byte first: byte cnt comes from position len-1-cnt
    assign bsel    = 2'(len_q - LEN_W'(1) - cnt);
    assign busy    = (state != ST_IDLE);
    assign {bc_start, bc_stop, bc_read, bc_write, bc_ack_in, bc_din} = cmd;

    always_comb begin
        arb_cmd       = '0;
        arb_cmd.start = 1'b1;
        arb_cmd.write = 1'b1;
        arb_cmd.din   = {req_sadr[win_idx], I2C_WR};
        issue         = '0;
        case (state)
            ST_RADR:    begin issue.write = 1'b1; issue.din = radr_q; end
            ST_WDATA:   begin
                issue.write = 1'b1;
                issue.stop  = last;
                issue.din   = wdata_q[{bsel, 3'b000} +: BYTE_W];
            end
            ST_RSTART:  begin issue.start = 1'b1; issue.write = 1'b1; issue.din = {sadr_q, I2C_RD}; end
            ST_RDATA:   begin issue.read = 1'b1; issue.ack_in = last; issue.stop = last; end
            ST_STOPERR: issue.stop = 1'b1;
            default:    ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            ptr      <= '0;
            gnt      <= '0;
            done     <= '0;
            err      <= '0;
            rdata    <= '0;
            cmd      <= '0;
            cmd_pend <= 1'b0;
            tmr      <= '0;
            cnt      <= '0;
            rw_q     <= 1'b0;
            sadr_q   <= '0;
            radr_q   <= '0;
            len_q    <= '0;
            wdata_q  <= '0;
        end else begin
            done <= '0;
            err  <= '0;
            case (state)
                ST_IDLE: if (|req) state <= ST_ARB;
                ST_ARB: begin
                    if (!(|req)) begin
                        state <= ST_IDLE;
                    end else begin
                        ptr     <= (win_idx == PW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
                        rw_q    <= req_rw[win_idx];
                        sadr_q  <= req_sadr[win_idx];
                        radr_q  <= req_radr[win_idx];
                        len_q   <= req_len[win_idx];
                        wdata_q <= req_wdata[win_idx];
                        rdata   <= '0;
                        cnt     <= '0;
                        tmr     <= '0;
                        if (len_bad) begin
                            err   <= arb_gnt;
                            state <= ST_IDLE;
                        end else begin
                            // grant and the address start go out on the same edge
                            gnt      <= arb_gnt;
                            cmd      <= arb_cmd;
                            cmd_pend <= 1'b1;
                            state    <= ST_SADR_W;
                        end
                    end
                end
                ST_DONE: begin
                    done  <= gnt;
                    gnt   <= '0;
                    state <= ST_IDLE;
                end
                default: begin
                    if (bc_al) begin
                        cmd      <= '0;
                        cmd_pend <= 1'b0;
                        err      <= gnt;
                        gnt      <= '0;
                        state    <= ST_IDLE;
                    end else if (!cmd_pend) begin
                        cmd      <= issue;
                        cmd_pend <= 1'b1;
                        tmr      <= '0;
                    end else if (bc_cmd_ack || tmr == TW'(TIMEOUT)) begin
                        cmd      <= '0;
                        cmd_pend <= 1'b0;
                        if (state == ST_STOPERR) begin
                            err   <= gnt;
                            gnt   <= '0;
                            state <= ST_IDLE;
                        end else if (!bc_cmd_ack || (cmd.write && bc_ack_out)) begin
                            state <= ST_STOPERR;
                        end else begin
                            case (state)
                                ST_SADR_W: state <= ST_RADR;
                                ST_RADR:   state <= rw_q ? ST_RSTART : ST_WDATA;
                                ST_RSTART: state <= ST_RDATA;
                                ST_WDATA, ST_RDATA: begin
                                    if (state == ST_RDATA)
                                        rdata <= {rdata[DATA_W-BYTE_W-1:0], bc_dout};
                                    if (last) state <= ST_DONE;
                                    else      cnt   <= cnt + 1'b1;
                                end
                                default:   state <= ST_IDLE;
                            endcase
                        end
                    end else begin
                        tmr <= tmr + 1'b1;
                    end
                end
            endcase
        end
    end
endmodule
